// File: rtl/bus_to_uart_tx.sv
// Serialises accepted 64-bit sample words as eight UART 8N1 bytes, byte 0 first.
// A one-deep holding register lets the next word queue up during transmission.
module bus_to_uart_tx #(
  parameter int CLKS_PER_BIT   = 434,
  parameter int BYTES_PER_WORD = 8
) (
  input  logic        fastclk,
  input  logic        reset,
  input  logic [63:0] in_bus,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        tx,
  output logic        busy,
  output logic        frame_done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    BYTE_LAST = 3'(BYTES_PER_WORD - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t        state_r;
  logic [63:0]   hold_r;
  logic [63:0]   shift_r;
  logic          hold_full_r;
  logic [CW-1:0] baud_cnt_r;
  logic [2:0]    bit_idx_r;
  logic [2:0]    byte_idx_r;
  logic          accept_s;
  logic          bit_end_s;

  assign accept_s  = in_valid && in_ready;
  assign bit_end_s = (baud_cnt_r == BAUD_LAST);

  // Handshake, holding register and transmit FSM with registered outputs.
  always_ff @(posedge fastclk) begin
    if (reset) begin
      state_r     <= IDLE;
      hold_r      <= 64'd0;
      shift_r     <= 64'd0;
      hold_full_r <= 1'b0;
      baud_cnt_r  <= '0;
      bit_idx_r   <= 3'd0;
      byte_idx_r  <= 3'd0;
      in_ready    <= 1'b1;
      tx          <= 1'b1;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      // in_ready drops on the accepting edge but only rises one edge after a reload.
      in_ready   <= accept_s ? 1'b0 : !hold_full_r;
      if (accept_s) begin
        hold_r      <= in_bus;
        hold_full_r <= 1'b1;
      end

      case (state_r)
        IDLE: begin
          baud_cnt_r <= '0;
          if (hold_full_r) begin
            shift_r     <= hold_r;
            hold_full_r <= 1'b0;
            byte_idx_r  <= 3'd0;
            tx          <= 1'b0;
            busy        <= 1'b1;
            state_r     <= START;
          end else begin
            tx   <= 1'b1;
            busy <= 1'b0;
          end
        end
        START: begin
          if (bit_end_s) begin
            baud_cnt_r <= '0;
            bit_idx_r  <= 3'd0;
            tx         <= shift_r[0];
            state_r    <= DATA;
          end else begin
            baud_cnt_r <= baud_cnt_r + 1'b1;
          end
        end
        DATA: begin
          if (bit_end_s) begin
            baud_cnt_r <= '0;
            shift_r    <= {1'b0, shift_r[63:1]};
            if (bit_idx_r == 3'd7) begin
              tx      <= 1'b1;
              state_r <= STOP;
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
              tx        <= shift_r[1];
            end
          end else begin
            baud_cnt_r <= baud_cnt_r + 1'b1;
          end
        end
        STOP: begin
          if (bit_end_s) begin
            baud_cnt_r <= '0;
            if (byte_idx_r != BYTE_LAST) begin
              byte_idx_r <= byte_idx_r + 3'd1;
              tx         <= 1'b0;
              state_r    <= START;
            end else begin
              frame_done <= 1'b1;
              if (hold_full_r) begin
                shift_r     <= hold_r;
                hold_full_r <= 1'b0;
                byte_idx_r  <= 3'd0;
                tx          <= 1'b0;
                state_r     <= START;
              end else begin
                tx      <= 1'b1;
                busy    <= 1'b0;
                state_r <= IDLE;
              end
            end
          end else begin
            baud_cnt_r <= baud_cnt_r + 1'b1;
          end
        end
        default: begin
          baud_cnt_r <= '0;
          tx         <= 1'b1;
          busy       <= 1'b0;
          state_r    <= IDLE;
        end
      endcase
    end
  end

endmodule
